cell_checker: RTL

Exhaustive truth-table checker for single-output combinational standard cells with up to 4 inputs. It sweeps every input vector into a cell instance, waits a programmable settle time, samples the cell output and compares it against a captured expected truth table. It reports pass/fail, the mismatch count and the first failing vector. It sits in the library-qualification bench and drives one cell instance per checker.

---
 rtl/cell_chk_pkg.sv | 14 +
 rtl/cell_chk_settle.sv | 25 ++
 rtl/cell_checker.sv | 107 ++++++++++
 3 files changed

// File: rtl/cell_chk_pkg.sv
// Shared types and widths for the cell truth-table checker.
package cell_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cell_chk_state_t;

  localparam int CELL_CHK_MAX_NIN = 4;
  localparam int CELL_CHK_TRUTH_W = 16;
  localparam int CELL_CHK_ERR_W   = 5;

endpackage

// File: rtl/cell_chk_settle.sv
// Loadable 4-bit settle down-counter; zero flags the sample cycle of a vector.
module cell_chk_settle (
  input  logic       cp,
  input  logic       cdn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge cp or negedge cdn) begin
    if (!cdn) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/cell_checker.sv
// Exhaustive truth-table sweep of a combinational cell with up to 4 inputs.
// Optional CELL_CHECKER_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module cell_checker
  import cell_chk_pkg::*;
#(
  parameter int NIN    = 4,
  parameter int SETTLE = 1
) (
  input  logic                        cp,
  input  logic                        cdn,
  input  logic                        start,
  input  logic [CELL_CHK_TRUTH_W-1:0] truth,
  output logic [NIN-1:0]              cell_in,
  input  logic                        cell_out,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [CELL_CHK_ERR_W-1:0]   err_cnt,
  output logic [CELL_CHK_MAX_NIN-1:0] first_fail
);

  localparam logic [NIN-1:0] VEC_LAST = '1;

  cell_chk_state_t             state;
  logic [NIN-1:0]              vec;
  logic [CELL_CHK_TRUTH_W-1:0] truth_q;
  logic                        zero;
  logic                        sample;
  logic                        mismatch;
  logic                        stop_hit;
  logic                        last;
  logic                        accept;
  logic [CELL_CHK_ERR_W-1:0]   err_nxt;

  assign cell_in  = vec;
  assign accept   = (state == IDLE) && start;
  assign sample   = (state == RUN) && zero;
  assign mismatch = sample && (cell_out != truth_q[vec]);
  assign err_nxt  = err_cnt + {{(CELL_CHK_ERR_W-1){1'b0}}, mismatch};

`ifdef CELL_CHECKER_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  // Termination is by compare on the last vector, never by counter wrap.
  assign last = (vec == VEC_LAST) || stop_hit;

  cell_chk_settle u_settle (
    .cp       (cp),
    .cdn      (cdn),
    .load     (accept || (sample && !last)),
    .load_val (4'(SETTLE)),
    .en       (state == RUN),
    .zero     (zero)
  );

  always_ff @(posedge cp or negedge cdn) begin
    if (!cdn) begin
      state      <= IDLE;
      vec        <= '0;
      truth_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            truth_q    <= truth;
            vec        <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          if (sample) begin
            err_cnt <= err_nxt;
            if (mismatch && err_cnt == '0) begin
              first_fail <= 4'(vec);
            end
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_nxt == '0);
            end else begin
              vec <= vec + NIN'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
